video_pattern_gen: RTL



---
 rtl/video_pattern_gen.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster timing and test-pattern source on the pixel clock.
// It drives the dv/hs/vs + 8-bit RGB stream that the HDMI receiver would otherwise drive.
// Optional build macro PATTERN_SCROLL_EN adds a per-frame horizontal scroll to the
// gray ramp and checkerboard patterns.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | counters held at (0,0), outputs at idle levels
// RUN    | counters free-run, frames repeat while en is high
// DRAIN  | en dropped; finish the current frame, then return to IDLE
module video_pattern_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1,
    parameter int unsigned CHK_LOG2 = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        dv_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic [7:0]  r_o,
    output logic [7:0]  g_o,
    output logic [7:0]  b_o,
    output logic        frame_start_o,
    output logic        busy_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam int unsigned BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    // Pattern x coordinate only needs the ramp byte and the checker bit.
    localparam int unsigned XW      = (CHK_LOG2 >= 8) ? CHK_LOG2 + 1 : 8;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [BW-1:0]   bar_px;
    logic [2:0]      bar_idx;
    logic [1:0]      pat_q;
    logic [23:0]     solid_q;
    logic            running, start, h_last, v_last, frame_end;
    logic            active, hs_act, vs_act, chk_v;
    logic [XW-1:0]   hx;
    logic [23:0]     pix;

    assign running   = (state != S_IDLE);
    assign start     = (state == S_IDLE) && en;
    assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_end = running && h_last && v_last;

    // Next-state logic; a DRAIN that sees en again rejoins RUN without a timing break.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (!en) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en)             state_nxt = S_RUN;
                else if (frame_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Raster counters; held at (0,0) while idle so RUN always starts at pixel (0,0).
    always_ff @(posedge clk) begin
        if (rst || !running) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Bar counter tracks h_cnt so colour-bar selection needs no divider.
    always_ff @(posedge clk) begin
        if (rst || !running || h_last) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_cnt < HW'(H_ACTIVE)) begin
            if (bar_px == BW'(BAR_W - 1)) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_px  <= bar_px + 1'b1;
            end
        end
    end

    // Pattern selection only changes on a frame boundary, never mid-frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q   <= '0;
            solid_q <= '0;
        end else if (start || frame_end) begin
            pat_q   <= pattern_sel;
            solid_q <= solid_rgb;
        end
    end

`ifdef PATTERN_SCROLL_EN
    logic [7:0] scroll;

    // Scroll offset advances once per frame and restarts with every new run.
    always_ff @(posedge clk) begin
        if (rst || start)   scroll <= '0;
        else if (frame_end) scroll <= scroll + 1'b1;
    end

    assign hx = XW'(h_cnt) + XW'(scroll);
`else
    assign hx = XW'(h_cnt);
`endif

    // Position decode and pixel colour for the current counter position.
    always_comb begin
        active = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
        hs_act = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
        vs_act = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
        chk_v  = |(v_cnt & (VW'(1) << CHK_LOG2));
        pix    = '0;
        case (pat_q)
            2'd0: pix = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
            2'd1: pix = {3{hx[7:0]}};
            2'd2: pix = (hx[CHK_LOG2] ^ chk_v) ? 24'hFFFFFF : 24'h000000;
            default: pix = solid_q;
        endcase
    end

    // Single output register stage; idle levels whenever the generator is stopped.
    always_ff @(posedge clk) begin
        if (rst || !running) begin
            dv_o          <= 1'b0;
            hs_o          <= ~HS_POL;
            vs_o          <= ~VS_POL;
            {r_o, g_o, b_o} <= '0;
            frame_start_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            dv_o          <= active;
            hs_o          <= hs_act ? HS_POL : ~HS_POL;
            vs_o          <= vs_act ? VS_POL : ~VS_POL;
            {r_o, g_o, b_o} <= active ? pix : 24'h000000;
            frame_start_o <= (h_cnt == '0) && (v_cnt == '0);
            busy_o        <= 1'b1;
        end
    end

endmodule
